// File: rtl/axis_upsizer_32to128_if.sv
`default_nettype none
// ============================================================================
// axis_upsizer_32to128_if : narrow AXIS input + packed wide output bundle
// Rev 1.0 - initial release
// ============================================================================
interface axis_upsizer_32to128_if #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
);
  logic [IN_WIDTH-1:0]       s_tdata;
  logic                      s_tvalid;
  logic                      s_tready;
  logic                      s_tlast;
  logic                      flush;
  logic [IN_WIDTH*RATIO-1:0] m_tdata;
  logic                      m_tvalid;
  logic                      m_tready;
  logic [RATIO-1:0]          m_tkeep;
  logic                      m_tlast;
  logic [31:0]               words_out;

  // Upsizer side: sinks the narrow stream, sources the packed word
  modport slave (
    input  s_tdata, s_tvalid, s_tlast, flush, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tkeep, m_tlast, words_out
  );

  // Environment side: drives the narrow stream, consumes the packed word
  modport master (
    output s_tdata, s_tvalid, s_tlast, flush, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tkeep, m_tlast, words_out
  );
endinterface
`default_nettype wire

// File: rtl/axis_upsizer_32to128.sv
`default_nettype none
// ============================================================================
// axis_upsizer_32to128 : packs RATIO narrow AXIS beats into one wide word,
// with tlast/flush early termination and a registered output slot.
// Rev 1.0 - initial release
// ============================================================================
module axis_upsizer_32to128 #(
  parameter int                  IN_WIDTH  = 32,
  parameter int                  RATIO     = 4,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                   aclk,
  input  logic                   reset,
  axis_upsizer_32to128_if.slave  bus
);
  localparam int                 c_OUT_W     = IN_WIDTH * RATIO;
  localparam int                 c_CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_LANE = c_CNT_W'(RATIO - 1);

  logic [c_CNT_W-1:0] r_lane_cnt;
  logic               r_flush_pend;
  logic [c_OUT_W-1:0] r_m_tdata;
  logic               r_m_tvalid;
  logic [RATIO-1:0]   r_m_tkeep;
  logic               r_m_tlast;
  logic [31:0]        r_words_out;

  logic               w_free;
  logic               w_s_tready;
  logic               w_accept;
  logic               w_handshake;
  logic               w_flush_req;
  logic               w_close_beat;
  logic               w_close_flush;
  logic               w_close;
  logic [c_OUT_W-1:0] w_word;
  logic [RATIO-1:0]   w_keep;

  assign w_free        = !r_m_tvalid || bus.m_tready;
  assign w_s_tready    = w_free && !reset;
  assign w_accept      = bus.s_tvalid && w_s_tready;
  assign w_handshake   = r_m_tvalid && bus.m_tready;
  assign w_flush_req   = bus.flush || r_flush_pend;
  assign w_close_beat  = w_accept && ((r_lane_cnt == c_LAST_LANE) || bus.s_tlast || w_flush_req);
  assign w_close_flush = !w_accept && w_flush_req && w_free && (r_lane_cnt != '0);
  assign w_close       = w_close_beat || w_close_flush;

  // Per-lane word assembly: stored lanes below the counter, the live beat at
  // the counter, padding above it. The top lane is never stored.
  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    localparam logic [c_CNT_W-1:0] c_IDX = c_CNT_W'(i);
    if (i < RATIO - 1) begin : g_acc
      logic [IN_WIDTH-1:0] r_acc;
      always_ff @(posedge aclk) begin
        if (reset || w_close) begin
          r_acc <= '0;
        end else if (w_accept && (r_lane_cnt == c_IDX)) begin
          r_acc <= bus.s_tdata;
        end
      end
      assign w_word[i*IN_WIDTH +: IN_WIDTH] =
          (c_IDX < r_lane_cnt)                  ? r_acc :
          ((c_IDX == r_lane_cnt) && w_accept)   ? bus.s_tdata : PAD_VALUE;
    end else begin : g_top
      assign w_word[i*IN_WIDTH +: IN_WIDTH] =
          ((c_IDX == r_lane_cnt) && w_accept) ? bus.s_tdata : PAD_VALUE;
    end
    assign w_keep[i] = (c_IDX < r_lane_cnt) || ((c_IDX == r_lane_cnt) && w_accept);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_lane_cnt   <= '0;
      r_flush_pend <= 1'b0;
      r_m_tdata    <= '0;
      r_m_tvalid   <= 1'b0;
      r_m_tkeep    <= '0;
      r_m_tlast    <= 1'b0;
      r_words_out  <= '0;
    end else begin
      if (w_close) begin
        r_m_tdata  <= w_word;
        r_m_tkeep  <= w_keep;
        r_m_tlast  <= w_close_beat && bus.s_tlast;
        r_m_tvalid <= 1'b1;
        r_lane_cnt <= '0;
      end else begin
        if (w_handshake) begin
          r_m_tvalid <= 1'b0;
        end
        if (w_accept) begin
          r_lane_cnt <= r_lane_cnt + c_CNT_W'(1);
        end
      end

      if (w_handshake) begin
        r_words_out <= r_words_out + 32'd1;
      end

      // A flush that cannot issue because the slot is occupied waits here
      if (bus.flush && !w_free && (r_lane_cnt != '0)) begin
        r_flush_pend <= 1'b1;
      end else if (w_free) begin
        r_flush_pend <= 1'b0;
      end
    end
  end

  assign bus.s_tready  = w_s_tready;
  assign bus.m_tdata   = r_m_tdata;
  assign bus.m_tvalid  = r_m_tvalid;
  assign bus.m_tkeep   = r_m_tkeep;
  assign bus.m_tlast   = r_m_tlast;
  assign bus.words_out = r_words_out;
endmodule
`default_nettype wire

// File: tb/tb_axis_upsizer_32to128.sv
`default_nettype none
// ============================================================================
// tb_axis_upsizer_32to128 : directed + randomized bench with a queue-based
// reference model of the packing rules.
// Rev 1.0 - initial release
// ============================================================================
module tb_axis_upsizer_32to128;
  localparam int              IN_W  = 32;
  localparam int              RATIO = 4;
  localparam int              OUT_W = IN_W * RATIO;
  localparam int              OBS_W = 1 + RATIO + OUT_W;
  localparam logic [IN_W-1:0] PAD   = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_upsizer_32to128_if #(.IN_WIDTH(IN_W), .RATIO(RATIO)) bus ();

  axis_upsizer_32to128 #(
    .IN_WIDTH (IN_W),
    .RATIO    (RATIO),
    .PAD_VALUE(PAD)
  ) dut (
    .aclk (clk),
    .reset(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: output slot, beats of the word being built
  bit               mdl_valid = 0;
  logic [OUT_W-1:0] mdl_data  = '0;
  logic [RATIO-1:0] mdl_keep  = '0;
  bit               mdl_last  = 0;
  logic [31:0]      mdl_words = '0;
  bit               mdl_pend  = 0;
  bit               mdl_acc   = 0;
  logic [IN_W-1:0]  part[$];
  logic [OBS_W-1:0] got[$];

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    bit free, freq, hs, close;
    int n;
    @(negedge clk);
    chk("m_tvalid", 160'(bus.m_tvalid), 160'(mdl_valid));
    if (mdl_valid) begin
      chk("m_tdata", 160'(bus.m_tdata), 160'(mdl_data));
      chk("m_tkeep", 160'(bus.m_tkeep), 160'(mdl_keep));
      chk("m_tlast", 160'(bus.m_tlast), 160'(mdl_last));
    end
    chk("s_tready", 160'(bus.s_tready), 160'((!mdl_valid || bus.m_tready) && !rst));
    chk("words_out", 160'(bus.words_out), 160'(mdl_words));
    if (bus.m_tvalid && bus.m_tready) got.push_back({bus.m_tlast, bus.m_tkeep, bus.m_tdata});

    if (rst) begin
      mdl_valid = 0; mdl_data = '0; mdl_keep = '0; mdl_last = 0;
      mdl_words = '0; mdl_pend = 0; mdl_acc = 0;
      part.delete();
    end else begin
      free  = !mdl_valid || bus.m_tready;
      freq  = bus.flush || mdl_pend;
      hs    = mdl_valid && bus.m_tready;
      close = 0;
      mdl_acc = bus.s_tvalid && free;
      if (mdl_acc) begin
        part.push_back(bus.s_tdata);
        close = (part.size() == RATIO) || bus.s_tlast || freq;
      end else begin
        close = freq && free && (part.size() > 0);
      end
      if (hs) mdl_words = mdl_words + 32'd1;
      if (!mdl_acc && bus.flush && !free && part.size() > 0) mdl_pend = 1;
      else if (free) mdl_pend = 0;
      if (close) begin
        n = part.size();
        for (int k = 0; k < RATIO; k++) begin
          mdl_data[k*IN_W +: IN_W] = (k < n) ? part[k] : PAD;
          mdl_keep[k] = (k < n);
        end
        mdl_last  = mdl_acc && bus.s_tlast;
        mdl_valid = 1;
        part.delete();
      end else if (hs) begin
        mdl_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [IN_W-1:0] d, input bit l, input bit f, input bit r);
    bus.s_tvalid = v;
    bus.s_tdata  = d;
    bus.s_tlast  = l;
    bus.flush    = f;
    bus.m_tready = r;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 1);
  endtask

  initial begin
    int beats;
    int cycles;
    bit hold;
    bit v, l, f, r;
    logic [IN_W-1:0] d;

    bus.s_tvalid = 0; bus.s_tdata = '0; bus.s_tlast = 0; bus.flush = 0; bus.m_tready = 0;
    rst = 1;
    @(posedge clk); #1;
    drive(0, '0, 0, 0, 1);
    rst = 0;
    chk("rst_m_tvalid", 160'(bus.m_tvalid), 160'(0));
    chk("rst_m_tdata", 160'(bus.m_tdata), 160'(0));
    chk("rst_words_out", 160'(bus.words_out), 160'(0));

    // Full words, back to back
    for (int i = 1; i <= 8; i++) drive(1, IN_W'(i), 0, 0, 1);
    idle(2);
    chk("full_cnt", 160'(got.size()), 160'(2));
    chk("full_w0", 160'(got[0]), 160'({1'b0, 4'hF, 128'h00000004_00000003_00000002_00000001}));
    chk("full_w1", 160'(got[1]), 160'({1'b0, 4'hF, 128'h00000008_00000007_00000006_00000005}));
    chk("full_words_out", 160'(bus.words_out), 160'(2));

    // tlast partial word
    got.delete();
    drive(1, 32'hA, 0, 0, 1);
    drive(1, 32'hB, 1, 0, 1);
    idle(2);
    chk("tlast_w", 160'(got[0]), 160'({1'b1, 4'b0011, 128'h00000000_00000000_0000000B_0000000A}));

    // Flush partial word, then flush with nothing pending
    got.delete();
    drive(1, 32'h11, 0, 0, 1);
    drive(1, 32'h22, 0, 0, 1);
    drive(1, 32'h33, 0, 0, 1);
    drive(0, '0, 0, 1, 1);
    idle(2);
    drive(0, '0, 0, 1, 1);
    idle(2);
    chk("flush_cnt", 160'(got.size()), 160'(1));
    chk("flush_w", 160'(got[0]), 160'({1'b0, 4'b0111, 128'h00000000_00000033_00000022_00000011}));

    // Backpressure hold
    got.delete();
    for (int i = 0; i < 4; i++) drive(1, IN_W'(32'h41 + i), 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h55, 0, 0, 0);
      chk("hold_s_tready", 160'(bus.s_tready), 160'(0));
    end
    drive(1, 32'h55, 0, 0, 1);
    drive(1, 32'h56, 0, 0, 1);
    drive(1, 32'h57, 0, 0, 1);
    drive(1, 32'h58, 0, 0, 1);
    idle(2);
    chk("hold_w0", 160'(got[0]), 160'({1'b0, 4'hF, 128'h00000044_00000043_00000042_00000041}));
    chk("hold_w1", 160'(got[1]), 160'({1'b0, 4'hF, 128'h00000058_00000057_00000056_00000055}));

    // Reset mid-word discards partial data
    got.delete();
    drive(1, 32'h1, 0, 0, 1);
    drive(1, 32'h2, 0, 0, 1);
    rst = 1;
    drive(0, '0, 0, 0, 1);
    rst = 0;
    chk("mid_rst_words_out", 160'(bus.words_out), 160'(0));
    for (int i = 0; i < 4; i++) drive(1, IN_W'(32'h21 + i), 0, 0, 1);
    idle(2);
    chk("mid_rst_w", 160'(got[0]), 160'({1'b0, 4'hF, 128'h00000024_00000023_00000022_00000021}));

    // Random traffic with tlast every 7th beat and sporadic flushes
    beats = 0; cycles = 0; hold = 0; v = 0; d = '0; l = 0;
    while (beats < 10000 && cycles < 90000) begin
      if (!hold) begin
        v = ($urandom_range(1, 0) == 1);
        d = $urandom;
        l = (beats % 7 == 6);
      end
      r = ($urandom_range(1, 0) == 1);
      f = ($urandom_range(15, 0) == 0);
      drive(v, d, v && l, f, r);
      cycles++;
      if (v && mdl_acc) begin
        beats++;
        hold = 0;
      end else begin
        hold = v;
      end
    end
    chk("rand_beats", 160'(beats), 160'(10000));
    drive(0, '0, 0, 1, 1);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axis_upsizer_32to128.md
Name: axis_upsizer_32to128

Overview:
- Upstream stage that feeds the MIG-based FIFO's 128-bit AXIS input (in_tdata/in_tvalid/in_tready).
- Packs a narrow AXIS source stream (default 32-bit) into full-width FIFO words, RATIO input beats per output word.
- Supports early termination: s_tlast or a flush strobe emits a partial word with unused lanes padded.
- Registered output stage; sustains one input beat per cycle while downstream is ready.

Parameters:
IN_WIDTH, 32, input data width in bits
RATIO, 4, input beats per output word; OUT width = IN_WIDTH*RATIO (128 by default)
PAD_VALUE, 0, IN_WIDTH-bit value written into unfilled lanes of a partial word

Ports:
aclk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
s_tdata  input  IN_WIDTH  input beat data
s_tvalid  input  1  input beat valid
s_tready  output  1  input beat accepted when s_tvalid&&s_tready
s_tlast  input  1  beat ends a packet; emit the current word after it
flush  input  1  one-cycle strobe; emit any partial word
m_tdata  output  IN_WIDTH*RATIO  packed word to FIFO in_tdata
m_tvalid  output  1  packed word valid
m_tready  input  1  downstream ready (FIFO in_tready)
m_tkeep  output  RATIO  per-lane valid mask, bit i covers lane i
m_tlast  output  1  word closed by s_tlast
words_out  output  32  count of words accepted downstream, wraps at 2^32

Behaviour:
- Reset (synchronous, active-high, aclk): m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, words_out=0. Lane counter and accumulator are cleared. A partial word in progress is discarded. s_tready=0 while reset is high.
- Lane order: first beat of a word goes in m_tdata[IN_WIDTH-1:0] (lane 0), beat k goes in lane k.
- State: lane_cnt 0..RATIO-1, accumulator of RATIO-1 lanes, keep mask, output register.
- Output slot free: free = !m_tvalid || m_tready. s_tready = free && !reset. This is a combinational path m_tready -> s_tready. Input stalls whenever the output register holds an unaccepted word, even while lower lanes are filling.
- Accepted beat (s_tvalid && s_tready):
  - The beat is written to lane lane_cnt.
  - If lane_cnt==RATIO-1, or s_tlast=1, or flush=1: the word is closed.
    - Output register loads accumulator plus this beat.
    - Unfilled lanes are loaded with PAD_VALUE.
    - m_tkeep bits 0..lane_cnt are set to 1, the rest to 0.
    - m_tlast=s_tlast, m_tvalid=1.
    - lane_cnt resets to 0 and the accumulator is cleared.
  - Otherwise lane_cnt increments.
- Flush with no accepted beat:
  - If lane_cnt>0 and free: the partial word (lanes 0..lane_cnt-1) is emitted with m_tlast=0, and lane_cnt returns to 0.
  - If lane_cnt==0: no effect.
  - If lane_cnt>0 and !free: the flush is held pending (sticky flag) and executes on the first cycle free=1. A beat accepted in that same cycle joins the flushed word.
- Latency: the word appears on m_tdata in the cycle after its closing beat is accepted.
- Throughput: one beat/cycle with m_tready held at 1. This gives RATIO input cycles per output word, with no bubbles.
- Output hold: m_tvalid=1 holds m_tdata, m_tkeep and m_tlast stable until m_tready.
- Simultaneous accept and reload: when m_tvalid && m_tready and a closing beat are in the same cycle, the register reloads and m_tvalid stays 1.
- words_out increments on each m_tvalid && m_tready.
- s_tlast on a lane-(RATIO-1) beat: single emission with m_tlast=1 and a full m_tkeep. There is no extra empty word.

Test Plan:
- Stream beats 0x00000001..0x00000008 with m_tready=1 and no tlast -> two words: 0x00000004_00000003_00000002_00000001 then 0x00000008_00000007_00000006_00000005. m_tkeep=4'hF, m_tlast=0, s_tready stays 1, words_out=2.
- Beats 0xA, 0xB with s_tlast on 0xB, PAD_VALUE=0 -> m_tdata=0x00000000_00000000_0000000B_0000000A, m_tkeep=4'b0011, m_tlast=1. The next word starts again at lane 0.
- Three beats 0x11, 0x22, 0x33, then a flush pulse with no beat -> m_tdata lanes {PAD, 0x33, 0x22, 0x11}, m_tkeep=4'b0111, m_tlast=0. A flush with lane_cnt=0 produces no output.
- Fill one word and hold m_tready=0 for 10 cycles -> m_tvalid=1 with stable data and s_tready=0 throughout. Releasing m_tready accepts the word and s_tready rises in the same cycle.
- Assert reset for 1 cycle after two beats of a word -> all outputs return to 0 and the partial data is lost. The next 4 beats form a clean word starting at lane 0.
- Random s_tvalid/m_tready (50% each), 10,000 beats, tlast every 7th beat -> a scoreboard matches every lane and keep mask. Also cover a pending flush raised while m_tready=0.
